// File: rtl/timestamp_capture_scheduler.sv
// timestamp_capture_scheduler: round-robin latch sequencer for two timestamp counter channels, 64-bit stamp FIFO and lo/hi 32-bit word serializer (define STAMP_DELTA_EN to store per-channel deltas)
module timestamp_capture_scheduler #(
  parameter int pDEPTH = 8,
  parameter int pTIMEOUT = 255,
  parameter int pDROPW = 16
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [1:0]        iEvent,
  output logic [1:0]        oLatch,
  output logic [1:0]        oResetLatch,
  input  logic [1:0]        iRdy,
  input  logic [31:0]       iCnt0Lo,
  input  logic [31:0]       iCnt0Hi,
  input  logic [31:0]       iCnt1Lo,
  input  logic [31:0]       iCnt1Hi,
  output logic [31:0]       oData,
  output logic              oValid,
  input  logic              iReady,
  output logic              oLast,
  output logic              oChan,
  output logic [pDROPW-1:0] oDropCnt,
  output logic              oTimeout
);
  localparam int AW = $clog2(pDEPTH);
  localparam int TW = $clog2(pTIMEOUT + 1);
  localparam logic [AW:0] FULL = (AW+1)'(pDEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [TW-1:0] TMAX = TW'(pTIMEOUT);
  localparam logic [pDROPW-1:0] DMAX = '1;
  typedef enum logic [2:0] {IDLE, LATCH, WAIT_RDY, CAPTURE, RELEASE} state_t;
  state_t state;
  logic [1:0] eventQ, pend, rise, serving, dropEv;
  logic chan, rrPtr, nextChan;
  logic [TW-1:0] tmr;
  logic [64:0] mem [pDEPTH];
  logic [AW-1:0] wp, rp, headIdx;
  logic [AW:0] count;
  logic [31:0] hiWord;
  logic [63:0] stamp, storeVal;
  logic [64:0] head;
  logic full, hiAcc, loAcc, push, capDrop, start;
  logic [pDROPW+1:0] dropSum;
`ifdef STAMP_DELTA_EN
  logic [63:0] refStamp [2];
`endif
  always_comb begin
    rise = iEvent & ~eventQ;
    serving = (state == IDLE) ? 2'b00 : {chan, ~chan};
    dropEv = rise & (pend | serving);
    nextChan = (&pend) ? ~rrPtr : pend[1];
    stamp = chan ? {iCnt1Hi, iCnt1Lo} : {iCnt0Hi, iCnt0Lo};
`ifdef STAMP_DELTA_EN
    storeVal = stamp - refStamp[chan];
`else
    storeVal = stamp;
`endif
    full = count == FULL;
    hiAcc = oValid && iReady && oLast;
    loAcc = oValid && iReady && !oLast;
    push = (state == CAPTURE) && (!full || hiAcc);
    capDrop = (state == CAPTURE) && !push;
    start = (count != '0) && (!oValid || (hiAcc && count > ONE));
    headIdx = hiAcc ? rp + 1'b1 : rp;
    head = mem[headIdx];
    dropSum = {2'b00, oDropCnt} + (pDROPW+2)'(dropEv[0]) + (pDROPW+2)'(dropEv[1]) + (pDROPW+2)'(capDrop);
  end
  always_ff @(posedge iCLK) begin
    if (push) mem[wp] <= {chan, storeVal};
  end
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state <= IDLE;
      eventQ <= '0;
      pend <= '0;
      chan <= 1'b0;
      rrPtr <= 1'b1;
      tmr <= '0;
      oLatch <= '0;
      oResetLatch <= '0;
      oTimeout <= 1'b0;
      oDropCnt <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
      hiWord <= '0;
      oData <= '0;
      oValid <= 1'b0;
      oLast <= 1'b0;
      oChan <= 1'b0;
`ifdef STAMP_DELTA_EN
      refStamp[0] <= '0;
      refStamp[1] <= '0;
`endif
    end else begin
      eventQ <= iEvent;
      oDropCnt <= (dropSum > {2'b00, DMAX}) ? DMAX : dropSum[pDROPW-1:0];
      pend <= (pend | (rise & ~dropEv)) & ~((state == LATCH) ? {chan, ~chan} : 2'b00);
      case (state)
        IDLE: if (|pend) begin
          chan <= nextChan;
          if (&pend) rrPtr <= nextChan;
          oLatch <= {nextChan, ~nextChan};
          state <= LATCH;
        end
        LATCH: begin
          tmr <= '0;
          state <= WAIT_RDY;
        end
        WAIT_RDY: if (iRdy[chan]) state <= CAPTURE;
          else if (tmr == TMAX) begin
            oTimeout <= 1'b1;
            oResetLatch <= oLatch;
            state <= RELEASE;
          end else tmr <= tmr + 1'b1;
        CAPTURE: begin
          oResetLatch <= oLatch;
          state <= RELEASE;
`ifdef STAMP_DELTA_EN
          if (push) refStamp[chan] <= stamp;
`endif
        end
        RELEASE: if (|oResetLatch) begin
          oLatch <= '0;
          oResetLatch <= '0;
          tmr <= '0;
        end else if (!iRdy[chan]) state <= IDLE;
          else if (tmr == TMAX) begin
            oTimeout <= 1'b1;
            state <= IDLE;
          end else tmr <= tmr + 1'b1;
        default: state <= IDLE;
      endcase
      if (push) wp <= wp + 1'b1;
      if (hiAcc) rp <= rp + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(hiAcc);
      if (start) begin
        oData <= head[31:0];
        hiWord <= head[63:32];
        oChan <= head[64];
        oLast <= 1'b0;
        oValid <= 1'b1;
      end else if (loAcc) begin
        oData <= hiWord;
        oLast <= 1'b1;
      end else if (hiAcc) oValid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_timestamp_capture_scheduler.sv
// tb_timestamp_capture_scheduler: vector table, corner sequences and random events checked against a stamp-queue model
module tb_timestamp_capture_scheduler;
  logic iCLK = 1'b0, iRST = 1'b1, iReady = 1'b0;
  logic [1:0] iEvent = 2'b00, iRdy = 2'b00;
  logic [31:0] iCnt0Lo = '0, iCnt0Hi = '0, iCnt1Lo = '0, iCnt1Hi = '0;
  logic [1:0] oLatch, oResetLatch;
  logic [31:0] oData;
  logic oValid, oLast, oChan, oTimeout;
  logic [15:0] oDropCnt;
  int total = 0, bad = 0;
  logic [64:0] expQ[$];
  int sinkMode = 0;
  bit sinkHi = 0;
  logic [63:0] cntVal [2] = '{64'h0, 64'h0};
  logic [63:0] refV [2] = '{64'h0, 64'h0};
  int rdyDly [2] = '{0, 0};
  int rdyCnt [2] = '{0, 0};
  bit rdyEn [2] = '{1, 1};
  int dropExp = 0;
  typedef struct {int chan; logic [63:0] cnt; int dly; logic [31:0] expLo; logic [31:0] expHi;} vec_t;
  vec_t vecs [5];

  always #5 iCLK = ~iCLK;

  timestamp_capture_scheduler dut (
    .iCLK(iCLK), .iRST(iRST), .iEvent(iEvent), .oLatch(oLatch), .oResetLatch(oResetLatch),
    .iRdy(iRdy), .iCnt0Lo(iCnt0Lo), .iCnt0Hi(iCnt0Hi), .iCnt1Lo(iCnt1Lo), .iCnt1Hi(iCnt1Hi),
    .oData(oData), .oValid(oValid), .iReady(iReady), .oLast(oLast), .oChan(oChan),
    .oDropCnt(oDropCnt), .oTimeout(oTimeout)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pushExp(input int c, input logic [63:0] v);
`ifdef STAMP_DELTA_EN
    expQ.push_back({c[0], v - refV[c]});
    refV[c] = v;
`else
    expQ.push_back({c[0], v});
`endif
  endtask

  task automatic pulse(input logic [1:0] m);
    @(negedge iCLK);
    iEvent = iEvent | m;
    @(negedge iCLK);
    iEvent = iEvent & ~m;
  endtask

  task automatic waitIdle();
    int n = 0;
    repeat (4) @(negedge iCLK);
    while ((oLatch != 2'b00 || oResetLatch != 2'b00 || iRdy != 2'b00) && n < 700) begin
      @(negedge iCLK);
      n++;
    end
    check("idle_bound", 64'(n < 700), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (expQ.size() > 0 && n < 3000) begin
      @(negedge iCLK);
      n++;
    end
    repeat (3) @(negedge iCLK);
    check("drain_bound", 64'(expQ.size()), 64'd0);
  endtask

  initial forever begin
    @(negedge iCLK);
    for (int c = 0; c < 2; c++) begin
      if (oResetLatch[c]) begin
        iRdy[c] = 1'b0;
        rdyCnt[c] = 0;
      end else if (oLatch[c] && rdyEn[c] && !iRdy[c]) begin
        if (rdyCnt[c] >= rdyDly[c]) iRdy[c] = 1'b1;
        else rdyCnt[c]++;
      end
    end
    {iCnt0Hi, iCnt0Lo} = cntVal[0];
    {iCnt1Hi, iCnt1Lo} = cntVal[1];
  end

  initial forever begin
    logic [64:0] e;
    logic [31:0] want;
    @(negedge iCLK);
    iReady = (sinkMode == 1) ? 1'b1 : (sinkMode == 2) ? 1'($urandom % 2) : 1'b0;
    if (oValid && iReady && !iRST) begin
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("FAIL word: unexpected word %0h last=%0b chan=%0b", oData, oLast, oChan);
      end else begin
        e = expQ[0];
        want = sinkHi ? e[63:32] : e[31:0];
        if (oData !== want || oLast !== sinkHi || oChan !== e[64]) begin
          bad++;
          $display("FAIL word: got data=%0h last=%0b chan=%0b expected data=%0h last=%0b chan=%0b",
                   oData, oLast, oChan, want, sinkHi, e[64]);
        end
        if (sinkHi) void'(expQ.pop_front());
        sinkHi = !sinkHi;
      end
    end
  end

  initial begin
    int n, k;
    logic [31:0] held;
    vecs[0] = '{0, 64'h0000_0001_0000_0010, 0, 32'h0000_0010, 32'h0000_0001};
    vecs[1] = '{1, 64'hDEAD_BEEF_1234_5678, 2, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[2] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[3] = '{1, 64'h0000_0000_0000_0000, 1, 32'h0000_0000, 32'h0000_0000};
    vecs[4] = '{0, 64'h8000_0000_0000_0001, 3, 32'h0000_0001, 32'h8000_0000};
    repeat (3) @(negedge iCLK);
    check("rst_latch", 64'(oLatch), 64'd0);
    check("rst_reslatch", 64'(oResetLatch), 64'd0);
    check("rst_valid", 64'(oValid), 64'd0);
    check("rst_data", 64'(oData), 64'd0);
    check("rst_last_chan", 64'({oLast, oChan}), 64'd0);
    check("rst_drop", 64'(oDropCnt), 64'd0);
    check("rst_timeout", 64'(oTimeout), 64'd0);
    iRST = 1'b0;
    sinkMode = 1;
    for (int i = 0; i < 5; i++) begin
      cntVal[vecs[i].chan] = vecs[i].cnt;
      rdyDly[vecs[i].chan] = vecs[i].dly;
      pushExp(vecs[i].chan, {vecs[i].expHi, vecs[i].expLo});
      pulse(vecs[i].chan == 0 ? 2'b01 : 2'b10);
      waitIdle();
      drain();
      check("vec_handshake_done", 64'({oLatch, oResetLatch, oValid}), 64'd0);
    end
    cntVal[0] = 64'h0000_00AA_0000_0A0A;
    cntVal[1] = 64'h0000_00BB_0000_0B0B;
    pushExp(0, cntVal[0]);
    pushExp(1, cntVal[1]);
    pulse(2'b11);
    waitIdle();
    drain();
    waitIdle();
    cntVal[0] = 64'h0000_00CC_0000_0C0C;
    cntVal[1] = 64'h0000_00DD_0000_0D0D;
    pushExp(1, cntVal[1]);
    pushExp(0, cntVal[0]);
    pulse(2'b11);
    waitIdle();
    drain();
    waitIdle();
    check("tie_drop", 64'(oDropCnt), 64'd0);
    rdyEn[0] = 0;
    cntVal[1] = 64'h1111_2222_3333_4444;
    pushExp(1, cntVal[1]);
    pulse(2'b01);
    n = 0;
    k = 0;
    while (!oTimeout && k < 1000) begin
      if (k == 5) iEvent[1] = 1'b1;
      if (k == 6) iEvent[1] = 1'b0;
      @(negedge iCLK);
      if (oLatch[0] && !oTimeout) n++;
      k++;
    end
    check("timeout_cycles", 64'(n), 64'd257);
    check("timeout_flag", 64'(oTimeout), 64'd1);
    check("timeout_no_write", 64'(oValid), 64'd0);
    drain();
    waitIdle();
    rdyEn[0] = 1;
    sinkMode = 0;
    rdyDly[0] = 1;
    for (int i = 0; i < 9; i++) begin
      cntVal[0] = 64'h0000_0100_0000_0000 + 64'(i * 3 + 7);
      if (i < 8) pushExp(0, cntVal[0]);
      pulse(2'b01);
      waitIdle();
    end
    check("full_drop", 64'(oDropCnt), 64'd1);
    check("full_head_valid", 64'({oValid, oLast}), 64'b10);
    held = oData;
    check("full_head_data", 64'(held), 64'(expQ[0][31:0]));
    repeat (5) @(negedge iCLK);
    check("full_stable", 64'(oData), 64'(held));
    sinkMode = 1;
    drain();
    check("full_drop_after", 64'(oDropCnt), 64'd1);
    rdyEn[0] = 0;
    pulse(2'b01);
    repeat (10) @(negedge iCLK);
    check("wait_latch_held", 64'(oLatch), 64'b01);
    #2 iRST = 1'b1;
    #1;
    check("mid_rst_latch", 64'({oLatch, oResetLatch}), 64'd0);
    check("mid_rst_out", 64'({oValid, oLast, oChan, oTimeout}), 64'd0);
    check("mid_rst_drop", 64'(oDropCnt), 64'd0);
    expQ.delete();
    sinkHi = 0;
    refV[0] = '0;
    refV[1] = '0;
    rdyEn[0] = 1;
    @(negedge iCLK);
    iRST = 1'b0;
    repeat (5) @(negedge iCLK);
    check("mid_rst_fifo_empty", 64'(oValid), 64'd0);
`ifdef STAMP_DELTA_EN
    cntVal[1] = 64'd100;
    expQ.push_back({1'b1, 64'd100});
    pulse(2'b10);
    waitIdle();
    cntVal[1] = 64'd350;
    expQ.push_back({1'b1, 64'd250});
    pulse(2'b10);
    waitIdle();
    drain();
    refV[1] = 64'd350;
`endif
    sinkMode = 2;
    for (int i = 0; i < 40; i++) begin
      int c;
      bit dbl;
      c = int'($urandom % 2);
      dbl = ($urandom % 4) == 0;
      cntVal[c] = {$urandom, $urandom};
      rdyDly[c] = int'($urandom % 6);
      pushExp(c, cntVal[c]);
      pulse(c == 0 ? 2'b01 : 2'b10);
      if (dbl) begin
        pulse(c == 0 ? 2'b01 : 2'b10);
        dropExp++;
      end
      waitIdle();
    end
    drain();
    check("rand_drop", 64'(oDropCnt), 64'(dropExp));
    check("rand_timeout_clear", 64'(oTimeout), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
